alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Driving end of the ALU operand/opcode interface.
- Sits at the ID/EX boundary of the MIPS pipeline:
  - decodes the main-control ALU class plus funct/opcode into the 4-bit ALU operation code;
  - selects forwarded operands;
  - builds the immediate operand;
  - registers everything so that the EX-stage ALU sees a stable opcode and operands for a full cycle.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
- WIDTH, 32, datapath width of operands and forwarded results.
- REGADDR, 5, width of the destination register index.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  synchronous, active-low reset.
- stallEX  input  1  hold the stage register contents.
- flushEX  input  1  replace the next stage contents with a bubble.
- validID  input  1  ID-stage instruction is real (not a bubble).
- aluClassID  input  2  class: 00 add, 01 sub, 10 R-type (use funct), 11 immediate (use opcode).
- opcodeID  input  6  instruction bits [31:26].
- functID  input  6  instruction bits [5:0].
- immID  input  16  instruction bits [15:0].
- aluSrcID  input  1  0 = operand B from register, 1 = operand B from extended immediate.
- regAID, regBID  input  WIDTH  register-file read data.
- fwdResultMEM  input  WIDTH  EX/MEM ALU result.
- fwdResultWB  input  WIDTH  MEM/WB writeback data.
- forwardA, forwardB  input  2  00 register file, 01 fwdResultWB, 10 fwdResultMEM, 11 register file.
- destRegID  input  REGADDR  destination register index.
- controlOpALU  output  4  registered ALU operation code.
- numberAALU  output  WIDTH  registered operand A.
- numberBALU  output  WIDTH  registered operand B.
- validEX  output  1  EX contents are a real instruction.
- illegalOpEX  output  1  the decode found no supported operation.
- destRegEX  output  REGADDR  registered destination index.
- storeDataEX  output  WIDTH  forwarded register B value, even when aluSrcID=1.

Behaviour:
- Op codes driven:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - 1111 means illegal; the ALU outputs 0 for it.
- Class 00 → 0010. Class 01 → 0110.
- Class 10, by funct:
  - 100000 or 100001 → 0010.
  - 100010 or 100011 → 0110.
  - 100100 → 0000.
  - 100101 → 0001.
  - 100111 → 1100.
  - 101010 → 0111.
  - Any other funct → 1111 with illegal=1.
- Class 11, by opcode:
  - 001000 addi → 0010, sign-extended immediate.
  - 001010 slti → 0111, sign-extended immediate.
  - 001100 andi → 0000, zero-extended immediate.
  - 001101 ori → 0001, zero-extended immediate.
  - Any other opcode → 1111 with illegal=1 and sign-extended immediate.
- Immediate extension for classes 00, 01 and 10 is sign extension.
- Immediate extension matters only when aluSrcID=1.
- Operand A is always the forwardA-selected source. Operand B is the forwardB-selected source, or the extended immediate when aluSrcID=1.
- Latency: decode and muxing are combinational from ID inputs; all outputs are registered on the rising clk edge, one cycle.
- Update priority, evaluated each rising edge:
  - resetN=0: all outputs 0. This applies even if stall or flush is asserted. controlOpALU resets to 0000.
  - else flushEX=1: bubble. validEX=0, illegalOpEX=0, controlOpALU=0000, operands/storeData/destReg=0. Flush overrides stall.
  - else stallEX=1: every output holds its previous value.
  - else: load decoded values; validEX=validID.
- If validID=0, the stage loads the decoded values but illegalOpEX is forced to 0. A bubble never flags illegal.
- Forwarded values are sampled in the loading cycle only. A stall does not re-sample forwarding.
- Simultaneous reset and flush: reset wins; the result is identical to the bubble except for the reset semantics.

Test Plan:
- Reset: hold resetN=0 two cycles with stallEX=1 → every output 0. Release, then load R-type funct 100010, A=7, B=3 → next cycle controlOpALU=0110, numberAALU=7, numberBALU=3, validEX=1.
- Immediate extension:
  - class 11, opcode 001100, imm=16'hFFFF, aluSrc=1 → numberBALU=32'h0000FFFF, op 0000.
  - opcode 001000, same imm → numberBALU=32'hFFFFFFFF, op 0010.
- Forwarding: regA=1, fwdResultMEM=5, fwdResultWB=9:
  - forwardA=10 → numberAALU=5.
  - forwardA=01 → 9.
  - forwardA=11 → 1.
  - forwardB=10 with aluSrc=1 and imm=4 → numberBALU=4, storeDataEX=5.
- Stall/flush:
  - Load op 0001, then stallEX=1 for 3 cycles while ID inputs change → outputs unchanged.
  - Assert stallEX and flushEX together → validEX=0, op=0000, operands 0.
- Illegal decode:
  - class 10, funct 000000, validID=1 → op 1111, illegalOpEX=1.
  - Same inputs with validID=0 → illegalOpEX=0, validEX=0.
- Exhaustive funct sweep: all 64 funct values under class 10 → exactly the six listed mappings (eight funct codes) are legal; the other 56 give 1111 with illegal=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ---------------
// ID/EX boundary register feeding the EX-stage ALU of a MIPS pipeline.
// Decodes the main-control ALU class together with funct/opcode into the
// 4-bit ALU operation code, selects forwarded operands, builds the extended
// immediate and registers everything for one full EX cycle.
//
// Ports:
//   clk           rising-edge clock
//   resetN        synchronous active-low reset (all outputs to zero)
//   stallEX       hold the stage register contents
//   flushEX       load a bubble (overrides stall)
//   validID       ID-stage instruction is real
//   aluClassID    00 add, 01 sub, 10 R-type (funct), 11 immediate (opcode)
//   opcodeID      instruction [31:26]
//   functID       instruction [5:0]
//   immID         instruction [15:0]
//   aluSrcID      0 = operand B from register, 1 = from extended immediate
//   regAID/regBID register-file read data
//   fwdResultMEM  EX/MEM ALU result
//   fwdResultWB   MEM/WB writeback data
//   forwardA/B    00/11 register file, 01 WB, 10 MEM
//   destRegID     destination register index
//   controlOpALU  registered ALU operation code (1111 = illegal)
//   numberAALU    registered operand A
//   numberBALU    registered operand B
//   validEX       EX contents are a real instruction
//   illegalOpEX   decode found no supported operation (never set for bubbles)
//   destRegEX     registered destination index
//   storeDataEX   forwarded register-B value, independent of aluSrcID
module alu_issue_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               stallEX,
    input  logic               flushEX,
    input  logic               validID,
    input  logic [1:0]         aluClassID,
    input  logic [5:0]         opcodeID,
    input  logic [5:0]         functID,
    input  logic [15:0]        immID,
    input  logic               aluSrcID,
    input  logic [WIDTH-1:0]   regAID,
    input  logic [WIDTH-1:0]   regBID,
    input  logic [WIDTH-1:0]   fwdResultMEM,
    input  logic [WIDTH-1:0]   fwdResultWB,
    input  logic [1:0]         forwardA,
    input  logic [1:0]         forwardB,
    input  logic [REGADDR-1:0] destRegID,
    output logic [3:0]         controlOpALU,
    output logic [WIDTH-1:0]   numberAALU,
    output logic [WIDTH-1:0]   numberBALU,
    output logic               validEX,
    output logic               illegalOpEX,
    output logic [REGADDR-1:0] destRegEX,
    output logic [WIDTH-1:0]   storeDataEX
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_ILL = 4'b1111;

    // ---------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------
    logic [3:0] op_dec;
    logic       illegal_dec;
    logic       zero_ext;

    always_comb begin
        op_dec      = OP_ILL;
        illegal_dec = 1'b0;
        zero_ext    = 1'b0;
        case (aluClassID)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (functID)
                    6'b100000, 6'b100001: op_dec = OP_ADD;
                    6'b100010, 6'b100011: op_dec = OP_SUB;
                    6'b100100:            op_dec = OP_AND;
                    6'b100101:            op_dec = OP_OR;
                    6'b100111:            op_dec = OP_NOR;
                    6'b101010:            op_dec = OP_SLT;
                    default:              illegal_dec = 1'b1;
                endcase
            end
            default: begin
                case (opcodeID)
                    6'b001000: op_dec = OP_ADD;
                    6'b001010: op_dec = OP_SLT;
                    6'b001100: begin
                        op_dec   = OP_AND;
                        zero_ext = 1'b1;
                    end
                    6'b001101: begin
                        op_dec   = OP_OR;
                        zero_ext = 1'b1;
                    end
                    default:   illegal_dec = 1'b1;
                endcase
            end
        endcase
    end

    // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
    logic [WIDTH-1:0] imm_ext;
    assign imm_ext = zero_ext ? {{(WIDTH-16){1'b0}}, immID}
                              : {{(WIDTH-16){immID[15]}}, immID};

    // ---------------------------------------------------------------
    // Forwarding muxes: index 0 = operand A, index 1 = operand B
    // ---------------------------------------------------------------
    logic [1:0][WIDTH-1:0] reg_data;
    logic [1:0][1:0]       fwd_sel;
    logic [1:0][WIDTH-1:0] fwd_data;

    assign reg_data[0] = regAID;
    assign reg_data[1] = regBID;
    assign fwd_sel[0]  = forwardA;
    assign fwd_sel[1]  = forwardB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // 11 falls back to the register file, same as 00.
            assign fwd_data[gi] = (fwd_sel[gi] == 2'b01) ? fwdResultWB  :
                                  (fwd_sel[gi] == 2'b10) ? fwdResultMEM :
                                                           reg_data[gi];
        end
    endgenerate

    logic [WIDTH-1:0] b_next;
    assign b_next = aluSrcID ? imm_ext : fwd_data[1];

    // ---------------------------------------------------------------
    // Stage register
    // ---------------------------------------------------------------
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               valid_reg;
    logic               illegal_reg;
    logic [REGADDR-1:0] dest_reg;
    logic [WIDTH-1:0]   store_reg;

    always_ff @(posedge clk) begin
        // Reset and flush produce the same all-zero bubble; reset simply
        // takes the same path with higher priority than stall.
        if (!resetN || flushEX) begin
            op_reg      <= OP_AND;
            a_reg       <= '0;
            b_reg       <= '0;
            valid_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            dest_reg    <= '0;
            store_reg   <= '0;
        end else if (!stallEX) begin
            op_reg      <= op_dec;
            a_reg       <= fwd_data[0];
            b_reg       <= b_next;
            valid_reg   <= validID;
            // A bubble coming down from ID must never raise illegal.
            illegal_reg <= illegal_dec & validID;
            dest_reg    <= destRegID;
            store_reg   <= fwd_data[1];
        end
    end

    assign controlOpALU = op_reg;
    assign numberAALU   = a_reg;
    assign numberBALU   = b_reg;
    assign validEX      = valid_reg;
    assign illegalOpEX  = illegal_reg;
    assign destRegEX    = dest_reg;
    assign storeDataEX  = store_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        resetN;
    logic        stallEX;
    logic        flushEX;
    logic        validID;
    logic [1:0]  aluClassID;
    logic [5:0]  opcodeID;
    logic [5:0]  functID;
    logic [15:0] immID;
    logic        aluSrcID;
    logic [31:0] regAID;
    logic [31:0] regBID;
    logic [31:0] fwdResultMEM;
    logic [31:0] fwdResultWB;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic [4:0]  destRegID;
    logic [3:0]  controlOpALU;
    logic [31:0] numberAALU;
    logic [31:0] numberBALU;
    logic        validEX;
    logic        illegalOpEX;
    logic [4:0]  destRegEX;
    logic [31:0] storeDataEX;

    alu_issue_stage #(.WIDTH(32), .REGADDR(5)) dut (
        .clk(clk), .resetN(resetN), .stallEX(stallEX), .flushEX(flushEX),
        .validID(validID), .aluClassID(aluClassID), .opcodeID(opcodeID),
        .functID(functID), .immID(immID), .aluSrcID(aluSrcID),
        .regAID(regAID), .regBID(regBID), .fwdResultMEM(fwdResultMEM),
        .fwdResultWB(fwdResultWB), .forwardA(forwardA), .forwardB(forwardB),
        .destRegID(destRegID), .controlOpALU(controlOpALU),
        .numberAALU(numberAALU), .numberBALU(numberBALU), .validEX(validEX),
        .illegalOpEX(illegalOpEX), .destRegEX(destRegEX),
        .storeDataEX(storeDataEX)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic        ill;
        logic [4:0]  dest;
        logic [31:0] store;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".op"},    32'(controlOpALU), 32'(e.op));
        chk({tag, ".a"},     numberAALU,        e.a);
        chk({tag, ".b"},     numberBALU,        e.b);
        chk({tag, ".valid"}, 32'(validEX),      32'(e.valid));
        chk({tag, ".ill"},   32'(illegalOpEX),  32'(e.ill));
        chk({tag, ".dest"},  32'(destRegEX),    32'(e.dest));
        chk({tag, ".store"}, storeDataEX,       e.store);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic string mnemonic(input logic [1:0] cls, input logic [5:0] opc,
                                       input logic [5:0] fn);
        if (cls == 2'd0) return "add";
        if (cls == 2'd1) return "sub";
        if (cls == 2'd2) begin
            if (fn == 6'd32 || fn == 6'd33) return "add";
            if (fn == 6'd34 || fn == 6'd35) return "sub";
            if (fn == 6'd36) return "and";
            if (fn == 6'd37) return "or";
            if (fn == 6'd39) return "nor";
            if (fn == 6'd42) return "slt";
            return "ill";
        end
        if (opc == 6'd8)  return "addi";
        if (opc == 6'd10) return "slti";
        if (opc == 6'd12) return "andi";
        if (opc == 6'd13) return "ori";
        return "ill";
    endfunction

    function automatic logic [3:0] op_of(input string m);
        if (m == "and" || m == "andi") return 4'd0;
        if (m == "or"  || m == "ori")  return 4'd1;
        if (m == "add" || m == "addi") return 4'd2;
        if (m == "sub")                return 4'd6;
        if (m == "slt" || m == "slti") return 4'd7;
        if (m == "nor")                return 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] r);
        if (f == 2'b01) return fwdResultWB;
        if (f == 2'b10) return fwdResultMEM;
        return r;
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t n;
        string m;
        logic [31:0] imm32;
        n = '0;
        if (!resetN || flushEX) return n;
        if (stallEX) return cur;
        m = mnemonic(aluClassID, opcodeID, functID);
        if (m == "andi" || m == "ori") imm32 = {16'h0, immID};
        else                           imm32 = 32'($signed(immID));
        n.op    = op_of(m);
        n.a     = pick(forwardA, regAID);
        n.store = pick(forwardB, regBID);
        n.b     = aluSrcID ? imm32 : n.store;
        n.valid = validID;
        n.ill   = validID && (m == "ill");
        n.dest  = destRegID;
        return n;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  cls;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic        src;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        vld;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mem;
        logic [31:0] wb;
        logic [4:0]  dst;
        exp_t        e;
    } vec_t;

    vec_t vecs[12];

    task automatic drive_vec(input vec_t v);
        aluClassID = v.cls; opcodeID = v.opc; functID = v.fn; immID = v.imm;
        aluSrcID = v.src; forwardA = v.fa; forwardB = v.fb; validID = v.vld;
        regAID = v.ra; regBID = v.rb; fwdResultMEM = v.mem; fwdResultWB = v.wb;
        destRegID = v.dst;
    endtask

    task automatic idle_inputs();
        stallEX = 0; flushEX = 0; validID = 1; aluClassID = 2'b00;
        opcodeID = 0; functID = 0; immID = 0; aluSrcID = 0;
        regAID = 0; regBID = 0; fwdResultMEM = 0; fwdResultWB = 0;
        forwardA = 0; forwardB = 0; destRegID = 0;
    endtask

    exp_t zero_e;
    exp_t held;
    exp_t mdl;
    exp_t nxt;
    int   legal_cnt;

    initial begin
        zero_e = '0;
        // {cls, opc, fn, imm, src, fa, fb, vld, ra, rb, mem, wb, dst, {op,a,b,valid,ill,dest,store}}
        vecs[0]  = '{2'b10, 6'h00, 6'b100010, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 32'd7, 32'd3, 32'd0, 32'd0, 5'd4,
                     '{4'b0110, 32'd7, 32'd3, 1'b1, 1'b0, 5'd4, 32'd3}};
        vecs[1]  = '{2'b11, 6'b001100, 6'h00, 16'hFFFF, 1'b1, 2'b00, 2'b00, 1'b1, 32'd0, 32'h1234, 32'd0, 32'd0, 5'd5,
                     '{4'b0000, 32'd0, 32'h0000FFFF, 1'b1, 1'b0, 5'd5, 32'h1234}};
        vecs[2]  = '{2'b11, 6'b001000, 6'h00, 16'hFFFF, 1'b1, 2'b00, 2'b00, 1'b1, 32'd0, 32'h1234, 32'd0, 32'd0, 5'd6,
                     '{4'b0010, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd6, 32'h1234}};
        vecs[3]  = '{2'b00, 6'h00, 6'h00, 16'h0000, 1'b0, 2'b10, 2'b00, 1'b1, 32'd1, 32'd2, 32'd5, 32'd9, 5'd1,
                     '{4'b0010, 32'd5, 32'd2, 1'b1, 1'b0, 5'd1, 32'd2}};
        vecs[4]  = '{2'b00, 6'h00, 6'h00, 16'h0000, 1'b0, 2'b01, 2'b00, 1'b1, 32'd1, 32'd2, 32'd5, 32'd9, 5'd1,
                     '{4'b0010, 32'd9, 32'd2, 1'b1, 1'b0, 5'd1, 32'd2}};
        vecs[5]  = '{2'b00, 6'h00, 6'h00, 16'h0000, 1'b0, 2'b11, 2'b00, 1'b1, 32'd1, 32'd2, 32'd5, 32'd9, 5'd1,
                     '{4'b0010, 32'd1, 32'd2, 1'b1, 1'b0, 5'd1, 32'd2}};
        vecs[6]  = '{2'b00, 6'h00, 6'h00, 16'h0004, 1'b1, 2'b00, 2'b10, 1'b1, 32'd1, 32'd2, 32'd5, 32'd9, 5'd2,
                     '{4'b0010, 32'd1, 32'd4, 1'b1, 1'b0, 5'd2, 32'd5}};
        vecs[7]  = '{2'b10, 6'h00, 6'b000000, 16'h0000, 1'b0, 2'b00, 2'b01, 1'b1, 32'd3, 32'd8, 32'd5, 32'd9, 5'd7,
                     '{4'b1111, 32'd3, 32'd9, 1'b1, 1'b1, 5'd7, 32'd9}};
        vecs[8]  = '{2'b10, 6'h00, 6'b000000, 16'h0000, 1'b0, 2'b00, 2'b01, 1'b0, 32'd3, 32'd8, 32'd5, 32'd9, 5'd7,
                     '{4'b1111, 32'd3, 32'd9, 1'b0, 1'b0, 5'd7, 32'd9}};
        vecs[9]  = '{2'b01, 6'h00, 6'h00, 16'h8000, 1'b1, 2'b00, 2'b00, 1'b1, 32'd10, 32'd20, 32'd0, 32'd0, 5'd8,
                     '{4'b0110, 32'd10, 32'hFFFF8000, 1'b1, 1'b0, 5'd8, 32'd20}};
        vecs[10] = '{2'b11, 6'b001101, 6'h00, 16'h8000, 1'b1, 2'b00, 2'b00, 1'b1, 32'd10, 32'd20, 32'd0, 32'd0, 5'd9,
                     '{4'b0001, 32'd10, 32'h00008000, 1'b1, 1'b0, 5'd9, 32'd20}};
        vecs[11] = '{2'b11, 6'b000000, 6'h00, 16'h8000, 1'b1, 2'b00, 2'b00, 1'b1, 32'd10, 32'd20, 32'd0, 32'd0, 5'd31,
                     '{4'b1111, 32'd10, 32'hFFFF8000, 1'b1, 1'b1, 5'd31, 32'd20}};

        // ---- reset held two cycles with stall asserted and busy inputs ----
        idle_inputs();
        drive_vec(vecs[0]);
        resetN = 0; stallEX = 1;
        step(); step();
        $display("reset: op=%h a=%h b=%h valid=%b", controlOpALU, numberAALU, numberBALU, validEX);
        chk_all("reset", zero_e);
        resetN = 1; stallEX = 0;

        // ---- directed table ----
        foreach (vecs[i]) begin
            drive_vec(vecs[i]);
            step();
            $display("vec %0d: op=%h a=%h b=%h valid=%b ill=%b store=%h",
                     i, controlOpALU, numberAALU, numberBALU, validEX, illegalOpEX, storeDataEX);
            chk_all($sformatf("vec%0d", i), vecs[i].e);
        end

        // ---- stall: load OR, then hold 3 cycles while inputs and forwards change ----
        idle_inputs();
        aluClassID = 2'b10; functID = 6'b100101; regAID = 32'h11; regBID = 32'h22;
        forwardA = 2'b10; fwdResultMEM = 32'hAA; destRegID = 5'd3;
        step();
        held = '{4'b0001, 32'hAA, 32'h22, 1'b1, 1'b0, 5'd3, 32'h22};
        $display("load or: op=%h a=%h b=%h", controlOpALU, numberAALU, numberBALU);
        chk_all("load_or", held);
        stallEX = 1;
        for (int c = 0; c < 3; c++) begin
            aluClassID = 2'(c + 1); functID = 6'(c); regAID = 32'(100 + c);
            regBID = 32'(200 + c); fwdResultMEM = 32'(300 + c); fwdResultWB = 32'(400 + c);
            validID = 1'(c); destRegID = 5'(20 + c);
            step();
            $display("stall %0d: op=%h a=%h b=%h", c, controlOpALU, numberAALU, numberBALU);
            chk_all($sformatf("stall%0d", c), held);
        end

        // ---- stall and flush together: flush wins ----
        flushEX = 1;
        step();
        $display("stall+flush: op=%h valid=%b", controlOpALU, validEX);
        chk_all("stall_flush", zero_e);
        stallEX = 0; flushEX = 0;

        // ---- reset together with flush after a legal load ----
        drive_vec(vecs[9]);
        step();
        chk_all("preload", vecs[9].e);
        resetN = 0; flushEX = 1;
        step();
        $display("reset+flush: op=%h valid=%b", controlOpALU, validEX);
        chk_all("reset_flush", zero_e);
        resetN = 1; flushEX = 0;

        // ---- exhaustive funct sweep under class 10 ----
        idle_inputs();
        aluClassID = 2'b10;
        legal_cnt = 0;
        for (int f = 0; f < 64; f++) begin
            logic legal;
            functID = 6'(f);
            legal = (f == 32 || f == 33 || f == 34 || f == 35 ||
                     f == 36 || f == 37 || f == 39 || f == 42);
            step();
            $display("funct %02h: op=%h ill=%b", f, controlOpALU, illegalOpEX);
            chk($sformatf("funct%0d.ill", f), 32'(illegalOpEX), 32'(!legal));
            if (!legal) chk($sformatf("funct%0d.op", f), 32'(controlOpALU), 32'd15);
            else        chk($sformatf("funct%0d.op", f), 32'(controlOpALU),
                            32'(op_of(mnemonic(2'b10, 6'h0, 6'(f)))));
            if (!illegalOpEX) legal_cnt++;
        end
        chk("legal_funct_count", 32'(legal_cnt), 32'd8);

        // ---- randomized run against the reference model ----
        resetN = 0;
        step();
        mdl = '0;
        chk_all("rand_reset", mdl);
        for (int t = 0; t < 400; t++) begin
            resetN       = ($urandom_range(0, 24) != 0);
            flushEX      = ($urandom_range(0, 9) == 0);
            stallEX      = ($urandom_range(0, 4) == 0);
            validID      = ($urandom_range(0, 5) != 0);
            aluClassID   = 2'($urandom_range(0, 3));
            opcodeID     = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(8, 13)) : 6'($urandom);
            functID      = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(32, 42)) : 6'($urandom);
            immID        = 16'($urandom);
            aluSrcID     = 1'($urandom);
            regAID       = $urandom;
            regBID       = $urandom;
            fwdResultMEM = $urandom;
            fwdResultWB  = $urandom;
            forwardA     = 2'($urandom);
            forwardB     = 2'($urandom);
            destRegID    = 5'($urandom);
            nxt = model_next(mdl);
            step();
            $display("rand %0d: rst=%b fl=%b st=%b op=%h a=%h b=%h v=%b ill=%b",
                     t, !resetN, flushEX, stallEX, controlOpALU, numberAALU, numberBALU,
                     validEX, illegalOpEX);
            chk_all($sformatf("rand%0d", t), nxt);
            mdl = nxt;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
